// File: rtl/sram_word_ctrl_if.sv
// Host-side request/response handshake for the word-to-byte SRAM controller.
// The host drives requests as master; the controller answers as slave.
interface sram_word_ctrl_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_word_ctrl.sv
// Word-to-byte SRAM initiator: each 32-bit request runs as four little-endian
// byte beats on an 8-bit single-port SRAM, each beat held 1+WAIT_STATES cycles.
module sram_word_ctrl #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  sram_word_ctrl_if.slave   bus,
  output logic              mem_nce,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [7:0]        mem_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [2:0] WS_L = 3'(WAIT_STATES);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        beat;
  logic [1:0]        beat_nx;
  logic [2:0]        wcnt;
  logic              beat_end;
  logic              last_beat;
  logic [ADDR_W-3:0] base_hi;
  logic [31:0]       wdata_q;
  logic [31:0]       wshift;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_nx;
  logic              data_oe;
  logic [7:0]        data_out;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^bus.req_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    beat_end  = (wcnt == WS_L);
    last_beat = (beat == 2'd3);
    beat_nx   = beat + 2'd1;
    wshift    = wdata_q >> {beat_nx, 3'b000};
    rdata_nx  = rdata_q;
    case (beat)
      2'd0: rdata_nx[7:0]   = mem_data;
      2'd1: rdata_nx[15:8]  = mem_data;
      2'd2: rdata_nx[23:16] = mem_data;
      2'd3: rdata_nx[31:24] = mem_data;
      default: ;
    endcase

    state_nx = state;
    case (state)
      IDLE:        if (bus.req_valid) state_nx = bus.req_we ? WRITE : READ;
      READ, WRITE: if (beat_end && last_beat) state_nx = DONE;
      DONE:        state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  // Bus outputs are loaded one edge ahead of the beat they describe, so the
  // accept edge already presents beat 0 and the DONE edge already idles the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat     <= '0;
      wcnt     <= '0;
      base_hi  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mem_nce  <= 1'b1;
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      data_oe  <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            beat     <= '0;
            wcnt     <= '0;
            base_hi  <= bus.req_addr[ADDR_W-1:2];
            wdata_q  <= bus.req_wdata;
            mem_nce  <= 1'b0;
            mem_re   <= !bus.req_we;
            mem_we   <= bus.req_we;
            mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            data_oe  <= bus.req_we;
            data_out <= bus.req_wdata[7:0];
          end
        end
        READ, WRITE: begin
          if (beat_end) begin
            wcnt <= '0;
            if (state == READ) rdata_q <= rdata_nx;
            if (last_beat) begin
              mem_nce <= 1'b1;
              mem_re  <= 1'b0;
              mem_we  <= 1'b0;
              data_oe <= 1'b0;
            end else begin
              beat     <= beat_nx;
              mem_addr <= {base_hi, beat_nx};
              data_out <= wshift[7:0];
            end
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_data      = data_oe ? data_out : 'z;
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_rdata = rdata_q;

  a_re_we_excl: assert property (@(posedge clk) disable iff (rst) !(mem_re && mem_we));
  a_drive_write: assert property (@(posedge clk) disable iff (rst) data_oe |-> (state == WRITE));
  a_nce_idle: assert property (@(posedge clk) disable iff (rst) (!mem_re && !mem_we) |-> mem_nce);

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: byte-SRAM models, a per-cycle request timeline model
// for the WAIT_STATES=0 instance, and directed checks for a WAIT_STATES=2 instance.
module tb_sram_word_ctrl;

  localparam int L0 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_word_ctrl_if #(.ADDR_W(11)) bus0 ();
  sram_word_ctrl_if #(.ADDR_W(11)) bus2 ();

  logic        nce0, re0, we0, nce2, re2, we2;
  logic [10:0] addr0, addr2;
  wire  [7:0]  data0, data2;
  logic [7:0]  sram0   [0:2047];
  logic [7:0]  sram2   [0:2047];
  logic [7:0]  ref_mem [0:2047];

  sram_word_ctrl #(.ADDR_W(11), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .mem_nce(nce0), .mem_re(re0), .mem_we(we0), .mem_addr(addr0), .mem_data(data0)
  );

  sram_word_ctrl #(.ADDR_W(11), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .mem_nce(nce2), .mem_re(re2), .mem_we(we2), .mem_addr(addr2), .mem_data(data2)
  );

  // Asynchronous-read byte SRAMs
  assign data0 = (!nce0 && re0) ? sram0[addr0] : 8'bz;
  assign data2 = (!nce2 && re2) ? sram2[addr2] : 8'bz;
  always @(posedge clk) if (!nce0 && we0) sram0[addr0] = data0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Request timeline model: phase -1 idle, 0..L0-1 beat cycles, L0 the response cycle.
  int          phase;
  logic        m_we;
  logic [10:0] m_base;
  logic [31:0] m_wdata;
  logic [31:0] exp_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase = -1;
      exp_rdata = '0;
    end else if (phase < 0) begin
      if (bus0.req_valid) begin
        phase   = 0;
        m_we    = bus0.req_we;
        m_base  = {bus0.req_addr[10:2], 2'b00};
        m_wdata = bus0.req_wdata;
      end
    end else begin
      if (phase < L0 && m_we) ref_mem[m_base + 11'(phase)] = m_wdata[8*phase +: 8];
      phase++;
      if (phase == L0 && !m_we)
        exp_rdata = {ref_mem[m_base + 11'd3], ref_mem[m_base + 11'd2],
                     ref_mem[m_base + 11'd1], ref_mem[m_base]};
      else if (phase > L0)
        phase = -1;
    end
  end

  always @(negedge clk) begin : compare
    logic [10:0] ea;
    logic [31:0] wsh;
    if (phase >= 0 && phase < L0) begin
      ea  = m_base + 11'(phase);
      wsh = m_wdata >> (8*phase);
      chk("beat_nce", nce0, 1'b0);
      chk("beat_addr", addr0, ea);
      chk("beat_re", re0, !m_we);
      chk("beat_we", we0, m_we);
      chk("beat_oe", dut0.data_oe, m_we);
      if (m_we) chk("wr_bus", data0, wsh[7:0]);
      else      chk("rd_bus", data0, ref_mem[ea]);
      chk("beat_rsp_valid", bus0.rsp_valid, 1'b0);
      chk("beat_ready", bus0.req_ready, 1'b0);
    end else begin
      chk("idle_nce", nce0, 1'b1);
      chk("idle_re", re0, 1'b0);
      chk("idle_we", we0, 1'b0);
      chk("idle_oe", dut0.data_oe, 1'b0);
      chk("rsp_valid", bus0.rsp_valid, phase == L0);
      chk("ready", bus0.req_ready, (phase < 0) && !rst);
      chk("rsp_rdata", bus0.rsp_rdata, exp_rdata);
    end
  end

  int we_cnt = 0, rdy_low_cnt = 0, rsp_cnt = 0;
  logic [10:0] q2[$];
  always @(negedge clk) begin
    if (we0) we_cnt++;
    if (!bus0.req_ready && !rst) rdy_low_cnt++;
    if (bus0.rsp_valid) rsp_cnt++;
    if (!nce2) q2.push_back(addr2);
  end

  task automatic issue0(input logic we, input logic [10:0] a, input logic [31:0] d);
    int n = 0;
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_addr  = a;
    bus0.req_wdata = d;
    while (!bus0.req_ready && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) chk("issue_ready", bus0.req_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_rsp0(input string name, input int exp_lat, input logic [31:0] exp_d,
                           input logic check_data);
    int n = 1;
    while (!bus0.rsp_valid && n < 60) begin @(negedge clk); n++; end
    chk({name, "_latency"}, n, exp_lat);
    if (check_data) chk({name, "_rdata"}, bus0.rsp_rdata, exp_d);
    @(negedge clk);
  endtask

  bit          seq_we [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [10:0] seq_a  [6] = '{11'h100, 11'h104, 11'h101, 11'h108, 11'h106, 11'h10B};
  logic [31:0] seq_d  [6] = '{32'hA5A55A5A, 32'h0F1E2D3C, 32'h0, 32'h87654321, 32'h0, 32'h0};

  initial begin : stim
    int w0, r0, c0, n;
    rst = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    for (int i = 0; i < 2048; i++) begin
      sram0[i] = 8'h00; sram2[i] = 8'h00; ref_mem[i] = 8'h00;
    end
    sram2[11'h040] = 8'h67; sram2[11'h041] = 8'h45;
    sram2[11'h042] = 8'h23; sram2[11'h043] = 8'h01;
    repeat (3) @(negedge clk);
    chk("reset_nce", nce0, 1'b1);
    chk("reset_addr", addr0, 11'h000);
    chk("reset_rdata", bus0.rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", bus0.req_ready, 1'b1);

    // Word write, little-endian byte order
    w0 = we_cnt; r0 = rdy_low_cnt;
    issue0(1'b1, 11'h010, 32'hDEADBEEF);
    bus0.req_valid = 1'b0;
    wait_rsp0("wr1", 5, 32'h0, 1'b0);
    chk("wr1_we_cycles", we_cnt - w0, 4);
    chk("wr1_ready_low", rdy_low_cnt - r0, 5);
    chk("wr1_b0", sram0[11'h010], 8'hEF);
    chk("wr1_b1", sram0[11'h011], 8'hBE);
    chk("wr1_b2", sram0[11'h012], 8'hAD);
    chk("wr1_b3", sram0[11'h013], 8'hDE);

    // Aligned and unaligned readback
    issue0(1'b0, 11'h010, 32'h0);
    bus0.req_valid = 1'b0;
    wait_rsp0("rd1", 5, 32'hDEADBEEF, 1'b1);
    issue0(1'b0, 11'h013, 32'h0);
    bus0.req_valid = 1'b0;
    wait_rsp0("rd_unaligned", 5, 32'hDEADBEEF, 1'b1);

    // Top of memory
    issue0(1'b1, 11'h7FF, 32'h11223344);
    bus0.req_valid = 1'b0;
    wait_rsp0("wr_top", 5, 32'h0, 1'b0);
    chk("wr_top_lo", sram0[11'h7FC], 8'h44);
    chk("wr_top_hi", sram0[11'h7FF], 8'h11);
    issue0(1'b0, 11'h7FF, 32'h0);
    bus0.req_valid = 1'b0;
    wait_rsp0("rd_top", 5, 32'h11223344, 1'b1);

    // Reset asserted during write beat 2
    c0 = rsp_cnt;
    issue0(1'b1, 11'h020, 32'hCAFEF00D);
    bus0.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_nce", nce0, 1'b1);
    chk("rst_we", we0, 1'b0);
    chk("rst_oe", dut0.data_oe, 1'b0);
    chk("rst_addr", addr0, 11'h000);
    chk("rst_rdata", bus0.rsp_rdata, 32'h0);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_rsp", rsp_cnt - c0, 0);
    chk("rst_b0", sram0[11'h020], 8'h0D);
    chk("rst_b1", sram0[11'h021], 8'hF0);
    chk("rst_b2", sram0[11'h022], 8'h00);
    chk("rst_b3", sram0[11'h023], 8'h00);
    issue0(1'b0, 11'h020, 32'h0);
    bus0.req_valid = 1'b0;
    wait_rsp0("rd_partial", 5, 32'h0000F00D, 1'b1);

    // Back-to-back with req_valid held high
    c0 = rsp_cnt;
    for (int i = 0; i < 6; i++) issue0(seq_we[i], seq_a[i], seq_d[i]);
    bus0.req_valid = 1'b0;
    n = 0;
    while (!bus0.req_ready && n < 60) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("b2b_completions", rsp_cnt - c0, 6);
    issue0(1'b0, 11'h10A, 32'h0);
    bus0.req_valid = 1'b0;
    wait_rsp0("b2b_pin", 5, 32'h87654321, 1'b1);

    // WAIT_STATES=2 read of a preloaded word
    bus2.req_valid = 1'b1;
    bus2.req_we    = 1'b0;
    bus2.req_addr  = 11'h040;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    n = 1;
    while (!bus2.rsp_valid && n < 80) begin @(negedge clk); n++; end
    chk("ws2_latency", n, 13);
    chk("ws2_rdata", bus2.rsp_rdata, 32'h01234567);
    chk("ws2_beat_cycles", q2.size(), 12);
    for (int i = 0; i < 12 && i < q2.size(); i++)
      chk("ws2_addr", q2[i], 11'h040 + 11'(i / 3));
    chk("ws2_no_write", we2, 1'b0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
